// File: rtl/bus_arbiter_rr.sv
// -----------------------------------------------------------------------------
// bus_arbiter_rr
//
// Round-robin arbiter and data mux for a shared PE data bus. Each cycle it
// picks one slave controller with a pending write, pulses that controller's
// grant, and in the same registered cycle drives the bus data, the source PE
// id and a one-hot read strobe to the addressed destination PE.
//
// A PE that has just been granted is held off for HOLDOFF cycles. This covers
// the time its controller needs to refresh valid_to_bus, so a stale request
// cannot be granted twice.
//
// Parameters
//   NUM_PE        number of slave controllers on the bus (>= 2)
//   BUS_ADDR_LEN  PE id width, NUM_PE <= 2**BUS_ADDR_LEN
//   DATA_LEN      bus data width
//   HOLDOFF       cycles a just-granted PE stays ineligible
//
// Ports
//   clk           clock
//   rst           synchronous reset, active-high
//   stall         freezes arbitration for the cycle
//   valid_to_bus  per-PE write request
//   data_to_bus   per-PE data, PE i at [i*DATA_LEN +: DATA_LEN]
//   addr_to_bus   per-PE destination id, PE i at [i*BUS_ADDR_LEN +: BUS_ADDR_LEN]
//   dest_ready    per-PE "can accept a read" (read buffer not full)
//   wr_to_bus     one-hot grant pulse to the source PE
//   rd_from_bus   one-hot read strobe to the destination PE
//   bus_data      data of the granted transfer (held while idle)
//   addr_bus      source PE id of the granted transfer (held while idle)
//   drop_err      pulse: granted destination id is not a real PE
//   xfer_count    transfers granted since reset, wraps
// -----------------------------------------------------------------------------
module bus_arbiter_rr #(
    parameter int NUM_PE       = 8,
    parameter int BUS_ADDR_LEN = 3,
    parameter int DATA_LEN     = 16,
    parameter int HOLDOFF      = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           stall,
    input  logic [NUM_PE-1:0]              valid_to_bus,
    input  logic [NUM_PE*DATA_LEN-1:0]     data_to_bus,
    input  logic [NUM_PE*BUS_ADDR_LEN-1:0] addr_to_bus,
    input  logic [NUM_PE-1:0]              dest_ready,
    output logic [NUM_PE-1:0]              wr_to_bus,
    output logic [NUM_PE-1:0]              rd_from_bus,
    output logic [DATA_LEN-1:0]            bus_data,
    output logic [BUS_ADDR_LEN-1:0]        addr_bus,
    output logic                           drop_err,
    output logic [31:0]                    xfer_count
);

    localparam int PTR_W      = $clog2(NUM_PE);
    localparam int HOLD_W     = (HOLDOFF < 1) ? 1 : $clog2(HOLDOFF + 1);
    localparam int ADDR_SPACE = 1 << BUS_ADDR_LEN;
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLDOFF);
    localparam logic [PTR_W-1:0]  LAST_PE   = PTR_W'(NUM_PE - 1);

    // Arbitration state
    logic [PTR_W-1:0]  ptr;
    logic [HOLD_W-1:0] hold_cnt [NUM_PE];

    // Request qualification
    logic [ADDR_SPACE-1:0] ready_ext;
    logic [NUM_PE-1:0]     eligible;

    // Winner selection
    logic                    found;
    logic [PTR_W-1:0]        win;
    logic [DATA_LEN-1:0]     win_data;
    logic [BUS_ADDR_LEN-1:0] win_dest;

    // Next-state values
    logic                    grant;
    logic                    dest_in_range;
    logic [NUM_PE-1:0]       wr_nxt;
    logic [NUM_PE-1:0]       rd_nxt;
    logic                    drop_nxt;
    logic [PTR_W-1:0]        ptr_nxt;
    logic [HOLD_W-1:0]       hold_nxt [NUM_PE];

    // ---- stage p0: request qualification ----

    // Ids beyond the last real PE read as always-ready, so a request to an
    // out-of-range destination is granted and drained (reported via drop_err)
    // rather than blocking its source forever.
    always_comb begin
        ready_ext               = '1;
        ready_ext[NUM_PE-1:0]   = dest_ready;
    end

    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_PE; i++) begin
            eligible[i] = valid_to_bus[i]
                        && (hold_cnt[i] == '0)
                        && ready_ext[addr_to_bus[i*BUS_ADDR_LEN +: BUS_ADDR_LEN]];
        end
    end

    // First eligible PE starting at the pointer, wrapping modulo NUM_PE.
    always_comb begin : search
        int idx;
        found    = 1'b0;
        win      = '0;
        win_data = '0;
        win_dest = '0;
        idx      = 0;
        for (int k = 0; k < NUM_PE; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_PE) begin
                idx = idx - NUM_PE;
            end
            if (!found && eligible[idx]) begin
                found    = 1'b1;
                win      = PTR_W'(idx);
                win_data = data_to_bus[idx*DATA_LEN +: DATA_LEN];
                win_dest = addr_to_bus[idx*BUS_ADDR_LEN +: BUS_ADDR_LEN];
            end
        end
    end

    always_comb begin
        grant         = found && !stall;
        dest_in_range = (int'(win_dest) < NUM_PE);
        wr_nxt        = '0;
        rd_nxt        = '0;
        drop_nxt      = 1'b0;
        ptr_nxt       = ptr;
        if (grant) begin
            wr_nxt[win] = 1'b1;
            for (int j = 0; j < NUM_PE; j++) begin
                if (j == int'(win_dest)) begin
                    rd_nxt[j] = 1'b1;
                end
            end
            drop_nxt = !dest_in_range;
            ptr_nxt  = (win == LAST_PE) ? '0 : win + 1'b1;
        end
    end

    // Holdoff counters keep running during stall; the winner is reloaded.
    always_comb begin
        for (int i = 0; i < NUM_PE; i++) begin
            hold_nxt[i] = (hold_cnt[i] != '0) ? hold_cnt[i] - 1'b1 : '0;
            if (grant && (win == PTR_W'(i))) begin
                hold_nxt[i] = HOLD_INIT;
            end
        end
    end

    // ---- stage p1: registered bus outputs ----

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr         <= '0;
            for (int i = 0; i < NUM_PE; i++) begin
                hold_cnt[i] <= '0;
            end
            wr_to_bus   <= '0;
            rd_from_bus <= '0;
            drop_err    <= 1'b0;
            bus_data    <= '0;
            addr_bus    <= '0;
            xfer_count  <= '0;
        end else begin
            ptr         <= ptr_nxt;
            hold_cnt    <= hold_nxt;
            wr_to_bus   <= wr_nxt;
            rd_from_bus <= rd_nxt;
            drop_err    <= drop_nxt;
            // Data and source id are held while the bus is idle.
            if (grant) begin
                bus_data   <= win_data;
                addr_bus   <= BUS_ADDR_LEN'(win);
                xfer_count <= xfer_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// -----------------------------------------------------------------------------
// tb_bus_arbiter_rr
//
// Two arbiter instances share clock, reset and stall: "a" with 8 PEs and
// "b" with 6 PEs (so destination ids 6 and 7 are out of range). A reference
// model works directly from the arbitration rules using integer pointers and
// per-PE holdoff counts, and every cycle all outputs of both instances are
// compared with it. Directed scenarios add fixed expected values.
// -----------------------------------------------------------------------------
module tb_bus_arbiter_rr;

    logic clk;
    logic rst;
    logic stall;

    // Stimulus, indexed [instance][pe]
    logic [7:0]  s_valid [2];
    logic [7:0]  s_ready [2];
    logic [15:0] s_data  [2][8];
    logic [2:0]  s_addr  [2][8];

    // Instance a (8 PEs)
    logic [7:0]   valid_a, ready_a, wr_a, rd_a;
    logic [127:0] data_a;
    logic [23:0]  addr_a;
    logic [15:0]  bus_data_a;
    logic [2:0]   addr_bus_a;
    logic         drop_a;
    logic [31:0]  cnt_a;

    // Instance b (6 PEs)
    logic [5:0]   valid_b, ready_b, wr_b, rd_b;
    logic [95:0]  data_b;
    logic [17:0]  addr_b;
    logic [15:0]  bus_data_b;
    logic [2:0]   addr_bus_b;
    logic         drop_b;
    logic [31:0]  cnt_b;

    // Reference model state and predicted outputs
    int          m_ptr  [2];
    int          m_hold [2][8];
    logic [31:0] m_cnt  [2];
    logic [7:0]  e_wr   [2];
    logic [7:0]  e_rd   [2];
    logic [15:0] e_data [2];
    logic [2:0]  e_addr [2];
    logic        e_drop [2];

    int    checks = 0;
    int    errors = 0;
    string phase  = "init";

    assign valid_a = s_valid[0];
    assign ready_a = s_ready[0];
    assign valid_b = s_valid[1][5:0];
    assign ready_b = s_ready[1][5:0];

    always_comb begin
        data_a = '0;
        addr_a = '0;
        data_b = '0;
        addr_b = '0;
        for (int i = 0; i < 8; i++) begin
            data_a[i*16 +: 16] = s_data[0][i];
            addr_a[i*3 +: 3]   = s_addr[0][i];
        end
        for (int i = 0; i < 6; i++) begin
            data_b[i*16 +: 16] = s_data[1][i];
            addr_b[i*3 +: 3]   = s_addr[1][i];
        end
    end

    bus_arbiter_rr #(.NUM_PE(8), .BUS_ADDR_LEN(3), .DATA_LEN(16), .HOLDOFF(2)) dut_a (
        .clk(clk), .rst(rst), .stall(stall),
        .valid_to_bus(valid_a), .data_to_bus(data_a), .addr_to_bus(addr_a),
        .dest_ready(ready_a),
        .wr_to_bus(wr_a), .rd_from_bus(rd_a), .bus_data(bus_data_a),
        .addr_bus(addr_bus_a), .drop_err(drop_a), .xfer_count(cnt_a)
    );

    bus_arbiter_rr #(.NUM_PE(6), .BUS_ADDR_LEN(3), .DATA_LEN(16), .HOLDOFF(2)) dut_b (
        .clk(clk), .rst(rst), .stall(stall),
        .valid_to_bus(valid_b), .data_to_bus(data_b), .addr_to_bus(addr_b),
        .dest_ready(ready_b),
        .wr_to_bus(wr_b), .rd_from_bus(rd_b), .bus_data(bus_data_b),
        .addr_bus(addr_bus_b), .drop_err(drop_b), .xfer_count(cnt_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s/%s: observed %0h expected %0h", phase, tag, obs, exp);
        end
    endtask

    // One clock of the arbitration rules for instance k.
    task automatic model_step(input int k);
        int n;
        int w;
        int i;
        int dest;
        logic ok;
        n = (k == 0) ? 8 : 6;
        e_wr[k]   = '0;
        e_rd[k]   = '0;
        e_drop[k] = 1'b0;
        if (rst) begin
            m_ptr[k] = 0;
            for (int j = 0; j < 8; j++) m_hold[k][j] = 0;
            m_cnt[k]  = '0;
            e_data[k] = '0;
            e_addr[k] = '0;
            return;
        end
        w = -1;
        if (!stall) begin
            for (int off = 0; off < n; off++) begin
                i    = (m_ptr[k] + off) % n;
                dest = int'(s_addr[k][i]);
                ok   = (dest >= n) ? 1'b1 : s_ready[k][dest];
                if (w < 0 && s_valid[k][i] && m_hold[k][i] == 0 && ok) w = i;
            end
        end
        for (int j = 0; j < n; j++) begin
            if (m_hold[k][j] > 0) m_hold[k][j] = m_hold[k][j] - 1;
        end
        if (w >= 0) begin
            dest        = int'(s_addr[k][w]);
            e_wr[k][w]  = 1'b1;
            e_data[k]   = s_data[k][w];
            e_addr[k]   = 3'(w);
            if (dest < n) e_rd[k][dest] = 1'b1;
            else          e_drop[k]     = 1'b1;
            m_ptr[k]    = (w + 1) % n;
            m_hold[k][w] = 2;
            m_cnt[k]    = m_cnt[k] + 32'd1;
        end
    endtask

    // Predict, clock, then compare every output of both instances.
    task automatic step();
        model_step(0);
        model_step(1);
        @(posedge clk);
        #1;
        chk("wr_a",   32'(wr_a),       32'(e_wr[0]));
        chk("rd_a",   32'(rd_a),       32'(e_rd[0]));
        chk("data_a", 32'(bus_data_a), 32'(e_data[0]));
        chk("src_a",  32'(addr_bus_a), 32'(e_addr[0]));
        chk("drop_a", 32'(drop_a),     32'(e_drop[0]));
        chk("cnt_a",  cnt_a,           m_cnt[0]);
        chk("wr_b",   32'(wr_b),       32'(e_wr[1][5:0]));
        chk("rd_b",   32'(rd_b),       32'(e_rd[1][5:0]));
        chk("data_b", 32'(bus_data_b), 32'(e_data[1]));
        chk("src_b",  32'(addr_bus_b), 32'(e_addr[1]));
        chk("drop_b", 32'(drop_b),     32'(e_drop[1]));
        chk("cnt_b",  cnt_b,           m_cnt[1]);
    endtask

    task automatic clear();
        for (int k = 0; k < 2; k++) begin
            s_valid[k] = '0;
            s_ready[k] = '1;
            for (int i = 0; i < 8; i++) begin
                s_data[k][i] = '0;
                s_addr[k][i] = '0;
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        logic [7:0] exp8;
        rst   = 1'b1;
        stall = 1'b0;
        clear();

        // Reset state
        phase = "reset";
        step();
        chk("rst_wr",  32'(wr_a), 32'h0);
        chk("rst_cnt", cnt_a,     32'h0);
        rst = 1'b0;

        // Single request, then holdoff before regrant
        phase = "single";
        s_valid[0]    = 8'h08;
        s_data[0][3]  = 16'h1234;
        s_addr[0][3]  = 3'd5;
        step();
        chk("t1_wr",   32'(wr_a),       32'h08);
        chk("t1_rd",   32'(rd_a),       32'h20);
        chk("t1_data", 32'(bus_data_a), 32'h1234);
        chk("t1_src",  32'(addr_bus_a), 32'h3);
        step();
        chk("t1_hold1", 32'(wr_a), 32'h00);
        step();
        chk("t1_hold2", 32'(wr_a), 32'h00);
        step();
        chk("t1_regrant", 32'(wr_a), 32'h08);
        clear();
        step();

        // All requesting: strict rotation
        phase = "rotate";
        do_reset();
        s_valid[0] = 8'hFF;
        for (int i = 0; i < 8; i++) begin
            s_data[0][i] = 16'($urandom);
            s_addr[0][i] = 3'($urandom_range(0, 7));
        end
        for (int j = 0; j < 9; j++) begin
            step();
            exp8 = 8'h01 << (j % 8);
            chk("t2_order", 32'(wr_a), 32'(exp8));
            if (j == 7) chk("t2_cnt8", cnt_a, 32'd8);
        end

        // Destination not ready blocks only that requester
        phase = "dest_ready";
        do_reset();
        clear();
        s_valid[0]   = 8'h06;
        s_addr[0][1] = 3'd6;
        s_addr[0][2] = 3'd0;
        s_ready[0]   = 8'hBF;
        step();
        chk("t3_pe2", 32'(wr_a), 32'h04);
        chk("t3_rd",  32'(rd_a), 32'h01);
        s_valid[0] = 8'h02;
        step();
        chk("t3_wait", 32'(wr_a), 32'h00);
        s_ready[0] = 8'hFF;
        step();
        chk("t3_pe1", 32'(wr_a), 32'h02);
        chk("t3_rd1", 32'(rd_a), 32'h40);
        clear();

        // Out-of-range destination on the 6-PE instance
        phase = "drop";
        s_valid[1]   = 8'h10;
        s_addr[1][4] = 3'd7;
        s_data[1][4] = 16'hBEEF;
        step();
        chk("t4_wr",   32'(wr_b),       32'h10);
        chk("t4_rd",   32'(rd_b),       32'h00);
        chk("t4_drop", 32'(drop_b),     32'h1);
        chk("t4_data", 32'(bus_data_b), 32'hBEEF);
        s_valid[1]   = 8'h04;
        s_addr[1][2] = 3'd6;
        s_data[1][2] = 16'h0A0A;
        step();
        chk("t4_wr6",   32'(wr_b),   32'h04);
        chk("t4_drop6", 32'(drop_b), 32'h1);
        s_valid[1] = 8'h00;
        step();
        chk("t4_idle_drop", 32'(drop_b),     32'h0);
        chk("t4_hold_data", 32'(bus_data_b), 32'h0A0A);
        chk("t4_hold_src",  32'(addr_bus_b), 32'h2);
        clear();

        // Stall freezes arbitration; holdoff keeps counting
        phase = "stall";
        do_reset();
        s_valid[0] = 8'h01;
        stall      = 1'b1;
        for (int j = 0; j < 3; j++) begin
            step();
            chk("t5_stalled", 32'(wr_a), 32'h0);
        end
        chk("t5_cnt_hold", cnt_a, 32'd0);
        stall = 1'b0;
        step();
        chk("t5_release", 32'(wr_a), 32'h01);
        chk("t5_cnt",     cnt_a,     32'd1);
        stall = 1'b1;
        step();
        step();
        stall = 1'b0;
        step();
        chk("t5_hold_in_stall", 32'(wr_a), 32'h01);
        clear();

        // Reset right after a grant
        phase = "mid_reset";
        s_valid[0]   = 8'h20;
        s_addr[0][5] = 3'd1;
        step();
        chk("t6_grant", 32'(wr_a), 32'h20);
        rst        = 1'b1;
        s_valid[0] = 8'hFF;
        step();
        chk("t6_wr0",   32'(wr_a),       32'h0);
        chk("t6_rd0",   32'(rd_a),       32'h0);
        chk("t6_data0", 32'(bus_data_a), 32'h0);
        chk("t6_cnt0",  cnt_a,           32'h0);
        rst = 1'b0;
        step();
        chk("t6_first", 32'(wr_a), 32'h01);

        // Randomized traffic against the model
        phase = "random";
        for (int c = 0; c < 400; c++) begin
            rst   = ($urandom_range(0, 99) == 0);
            stall = ($urandom_range(0, 9) == 0);
            for (int k = 0; k < 2; k++) begin
                s_valid[k] = 8'($urandom);
                s_ready[k] = 8'($urandom) | 8'($urandom);
                for (int i = 0; i < 8; i++) begin
                    s_data[k][i] = 16'($urandom);
                    s_addr[k][i] = 3'($urandom_range(0, 7));
                end
            end
            step();
        end
        rst   = 1'b0;
        stall = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
